shiftadd_mult: RTL and testbench

SHIFTADD_MULT -- requirements
Module: shiftadd_mult

---
 rtl/mult_pkg.sv | 14 +
 rtl/shiftadd_mult.sv | 111 +++++++++++
 tb/tb_shiftadd_mult.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   mult_state_e       : FSM state encoding (IDLE / BUSY / DONE)
//   MULT_WIDTH_DEFAULT : default operand width in bits
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  localparam int MULT_WIDTH_DEFAULT = 512;

endpackage

// File: rtl/shiftadd_mult.sv
// Iterative unsigned shift-and-add multiplier: one partial product per cycle.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request to begin a multiply
//   A, B      : unsigned multiplicand / multiplier (WIDTH bits)
//   busy      : high while iterating
//   done      : one-cycle completion pulse; P is valid from this cycle on
//   P         : unsigned product A*B (2*WIDTH bits), held until next done/reset
//   state_dbg : current FSM state, for observation only
//
// Handshake: start is a single-cycle request with no ready signal. It is
// accepted only at an edge where the FSM is IDLE; A and B are captured at
// that same edge and ignored at every other time. start in BUSY/DONE is dropped.
//
// Build option: define SHIFTADD_MULT_EARLY_TERM_EN to end iteration as soon as
// the remaining multiplier bits are all zero. The product is identical either way.
module shiftadd_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output mult_state_e        state_dbg
);

  // One extra bit so the counter can represent WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mult_state_e        state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] ash;
  logic [WIDTH-1:0]   bsh;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   bsh_next;
  logic               last_iter;

  always_comb begin
    acc_next = bsh[0] ? (acc + ash) : acc;
    bsh_next = bsh >> 1;
`ifdef SHIFTADD_MULT_EARLY_TERM_EN
    // Stop once no set multiplier bits remain; the count bound still applies.
    last_iter = (bsh_next == '0) || (cnt == LAST_CNT);
`else
    last_iter = (cnt == LAST_CNT);
`endif
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      acc   <= '0;
      ash   <= '0;
      bsh   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ash   <= {{WIDTH{1'b0}}, A};
            bsh   <= B;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          ash <= ash << 1;
          bsh <= bsh_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            // Load P with the final accumulation so it is valid together with done.
            P     <= acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult.sv
// Directed bench for shiftadd_mult with an 8-bit and a 512-bit instance.
// Cycle n is the clock period following rising edge n; start is sampled at edge 0.
module tb_shiftadd_mult;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start8, busy8, done8;
  logic [7:0]    a8, b8;
  logic [15:0]   p8;
  mult_state_e   st8;

  logic          start512, busy512, done512;
  logic [511:0]  a512, b512;
  logic [1023:0] p512;
  mult_state_e   st512;

  shiftadd_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8), .state_dbg(st8)
  );

  shiftadd_mult #(.WIDTH(512)) u_dut512 (
    .clk(clk), .rst_n(rst_n), .start(start512), .A(a512), .B(b512),
    .busy(busy512), .done(done512), .P(p512), .state_dbg(st512)
  );

  // ---------------- scoreboard ----------------
  logic [1023:0] exp_q[$];
  logic [15:0]   last_p8;
  logic [1023:0] last_p512;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected BUSY cycle count for an operand width w and multiplier b.
  function automatic int exp_busy_cycles(input int w, input logic [511:0] b);
    int n;
`ifdef SHIFTADD_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < w; i++) if (b[i]) n = i + 1;
`else
    n = w;
`endif
    return n;
  endfunction

  // ---------------- drivers ----------------
  // Run one 8-bit multiply; optionally inject a second start at cycle inj_cyc.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj_cyc, input string tag);
    int lat;
    int done_cnt;
    logic [1023:0] exp_p;
    lat = exp_busy_cycles(8, {504'd0, b});
    exp_q.push_back({1008'd0, 8'd0, a} * {1008'd0, 8'd0, b});
    done_cnt = 0;
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    for (int cyc = 1; cyc <= lat + 3; cyc++) begin
      chk({tag, "_busy"}, {1023'd0, busy8}, {1023'd0, (cyc <= lat)});
      chk({tag, "_done"}, {1023'd0, done8}, {1023'd0, (cyc == lat + 1)});
      if (done8) begin
        done_cnt++;
        if (done_cnt == 1) begin
          exp_p = exp_q.pop_front();
          last_p8 = exp_p[15:0];
        end
      end
      chk({tag, "_p"}, {1008'd0, p8}, {1008'd0, last_p8});
      if (cyc == inj_cyc) begin
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    chk({tag, "_done_count"}, 1024'(done_cnt), 1024'd1);
  endtask

  task automatic op512(input logic [511:0] a, input logic [511:0] b, input string tag);
    int lat;
    int done_cnt;
    lat = exp_busy_cycles(512, b);
    exp_q.push_back({512'd0, a} * {512'd0, b});
    done_cnt = 0;
    start512 = 1'b1; a512 = a; b512 = b;
    @(posedge clk); #1;
    start512 = 1'b0; a512 = '0; b512 = '0;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      if (busy512 !== (cyc <= lat) || cyc == 1 || cyc == lat)
        chk({tag, "_busy"}, {1023'd0, busy512}, {1023'd0, (cyc <= lat)});
      if (done512 !== (cyc == lat + 1) || cyc == lat + 1)
        chk({tag, "_done"}, {1023'd0, done512}, {1023'd0, (cyc == lat + 1)});
      if (done512) begin
        done_cnt++;
        if (done_cnt == 1) last_p512 = exp_q.pop_front();
      end
      if (p512 !== last_p512 || cyc == lat + 2)
        chk({tag, "_p"}, p512, last_p512);
      @(posedge clk); #1;
    end
    chk({tag, "_done_count"}, 1024'(done_cnt), 1024'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1023:0] p_formula;
    logic [1023:0] discard;
    checks = 0; failures = 0;
    last_p8 = '0; last_p512 = '0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start512 = 1'b0; a512 = '0; b512 = '0;
    #2;
    chk("rst_busy8", {1023'd0, busy8}, 1024'd0);
    chk("rst_done8", {1023'd0, done8}, 1024'd0);
    chk("rst_p8", {1008'd0, p8}, 1024'd0);
    chk("rst_state8", {1022'd0, st8}, {1022'd0, IDLE});
    chk("rst_busy512", {1023'd0, busy512}, 1024'd0);
    chk("rst_p512", p512, 1024'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    op8(8'd255, 8'd255, -1, "max8");
    op8(8'd200, 8'd3, -1, "b3");
    op8(8'h5A, 8'd0, -1, "bzero");
    op8(8'd3, 8'd5, 4, "ignore_start");
    op8(8'd1, 8'd128, -1, "b_msb");
    op8(8'd255, 8'd1, -1, "b_one");
    for (int i = 0; i < 4; i++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, "rand8");

    // Abort mid-operation with reset.
    exp_q.push_back(1024'd0);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'hA5;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", {1023'd0, busy8}, 1024'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {1023'd0, busy8}, 1024'd0);
    chk("abort_done", {1023'd0, done8}, 1024'd0);
    chk("abort_p", {1008'd0, p8}, 1024'd0);
    chk("abort_state", {1022'd0, st8}, {1022'd0, IDLE});
    discard = exp_q.pop_back();
    last_p8 = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {1023'd0, done8}, 1024'd0);
    end
    rst_n = 1'b1;
    op8(8'd13, 8'd11, -1, "after_reset");

    // Full-width corner.
    p_formula = 1024'd0 - (1024'd1 << 513) + 1024'd1;
    op512({512{1'b1}}, {512{1'b1}}, "max512");
    chk("max512_formula", p512, p_formula);

    chk("queue_empty", 1024'(exp_q.size()), 1024'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
